// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit CPU sequencer slice:
//   - opcode constants carried in ir[15:12]
//   - ALU operation codes driven towards the datapath
//   - FSM state encoding (also visible on the sequencer's state output)
//   - instruction field positions and a helper to extract the opcode
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  // LW and SW reuse the adder for address generation, hence ALU_ADD.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERROR  = 3'd7
  } seq_state_t;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
// Memory handshake between the sequencer (master) and the shared
// single-port memory (slave).
//   mem_req      : request, held until mem_ready is seen
//   mem_we       : write enable (stores only)
//   mem_sel_data : address mux select, 0 = pc, 1 = ALU result
//   mem_ready    : completion strobe from memory
//   instr_rdata  : read data, captured into ir during fetch
// ---------------------------------------------------------------------------
interface cpu_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_sel_data;
  logic        mem_ready;
  logic [15:0] instr_rdata;

  modport master (
    output mem_req, mem_we, mem_sel_data,
    input  mem_ready, instr_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_sel_data,
    output mem_ready, instr_rdata
  );
endinterface

// File: rtl/cpu_seq_decode.sv
// ---------------------------------------------------------------------------
// cpu_seq_decode
// Purely combinational opcode classifier.
//   opcode     in  4 : ir[15:12]
//   alu_op     out 4 : ALU operation for the datapath
//   is_alu     out 1 : ADD/SUB/AND/OR
//   is_load    out 1 : LW
//   is_store   out 1 : SW
//   is_halt    out 1 : HALT
//   is_illegal out 1 : opcodes 7..E
// NOP is the case where every class flag is low.
// ---------------------------------------------------------------------------
module cpu_seq_decode (
  input  logic [3:0] opcode,
  output logic [3:0] alu_op,
  output logic       is_alu,
  output logic       is_load,
  output logic       is_store,
  output logic       is_halt,
  output logic       is_illegal
);
  import cpu_pkg::*;

  always_comb begin
    alu_op     = ALU_ADD;
    is_alu     = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_ADD:  is_alu = 1'b1;
      OP_SUB:  begin is_alu = 1'b1; alu_op = ALU_SUB; end
      OP_AND:  begin is_alu = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin is_alu = 1'b1; alu_op = ALU_OR;  end
      OP_LW:   is_load  = 1'b1;
      OP_SW:   is_store = 1'b1;
      OP_HALT: is_halt  = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM for the 16-bit CPU: fetch, decode, execute,
// memory access and writeback. Owns pc, ir and the memory handshake.
//
// Parameters: PC_WIDTH (pc wraps modulo 2^PC_WIDTH),
//             MEM_TIMEOUT (max wait cycles for mem_ready, 0 = no timeout)
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   run             : level enable, sampled in IDLE and at retire
//   mem             : memory handshake (cpu_sequencer_if.master)
//   pc, ir          : program counter, instruction register
//   alu_op, alu_en  : ALU control, alu_en pulses in EXEC
//   rf_we, rf_waddr, rf_wsel : register-file write control (WB)
//   state           : current FSM state encoding
//   halted, err     : sticky terminal flags
//   instr_count     : retired-instruction counter
// Optional feature macro: CPU_SEQ_PERF_CNT_EN enables the saturating
// retired-instruction counter; otherwise instr_count is tied to 0.
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  cpu_sequencer_if.master     mem,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         ir,
  output logic [3:0]          alu_op,
  output logic                alu_en,
  output logic                rf_we,
  output logic [3:0]          rf_waddr,
  output logic                rf_wsel,
  output logic [2:0]          state,
  output logic                halted,
  output logic                err,
  output logic [15:0]         instr_count
);
  import cpu_pkg::*;

  localparam int            TW       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit            TMO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  seq_state_t    cur_state;
  seq_state_t    state_next;
  logic [TW-1:0] tmo_cnt;
  logic          ir_load;
  logic          retire;
  logic          mem_wait;
  logic          tmo_expire;
  logic [3:0]    opcode;
  logic          dec_alu;
  logic          dec_load;
  logic          dec_store;
  logic          dec_halt;
  logic          dec_illegal;

  assign opcode = opcode_of(ir);

  cpu_seq_decode u_decode (
    .opcode     (opcode),
    .alu_op     (alu_op),
    .is_alu     (dec_alu),
    .is_load    (dec_load),
    .is_store   (dec_store),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  // The counter value equals the number of wait cycles already spent, so
  // the request gives up in its MEM_TIMEOUT-th unanswered cycle.
  assign mem_wait   = ((cur_state == FETCH) || (cur_state == MEM)) && !mem.mem_ready;
  assign tmo_expire = TMO_EN && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= state_next;
  end

  // Next-state logic. Every retire point funnels through the same run check
  // at the bottom so run is never looked at mid-instruction.
  always_comb begin
    state_next = cur_state;
    ir_load    = 1'b0;
    retire     = 1'b0;
    case (cur_state)
      IDLE:   if (run) state_next = FETCH;
      FETCH: begin
        if (mem.mem_ready) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end else if (tmo_expire) begin
          state_next = ERROR;
        end
      end
      DECODE: begin
        if (dec_halt)                              state_next = HALT;
        else if (dec_illegal)                      state_next = ERROR;
        else if (dec_alu || dec_load || dec_store) state_next = EXEC;
        else                                       retire     = 1'b1;
      end
      EXEC:   state_next = dec_alu ? WB : MEM;
      MEM: begin
        if (mem.mem_ready) begin
          if (dec_store) retire     = 1'b1;
          else           state_next = WB;
        end else if (tmo_expire) begin
          state_next = ERROR;
        end
      end
      WB:     retire = 1'b1;
      HALT:   state_next = HALT;
      ERROR:  state_next = ERROR;
      default: state_next = ERROR;
    endcase
    if (retire) state_next = run ? FETCH : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
      ir <= '0;
    end else if (ir_load) begin
      pc <= pc + PC_WIDTH'(1);
      ir <= mem.instr_rdata;
    end
  end

  // Any state change clears the wait counter, which covers entry to both
  // FETCH and MEM without tracking the previous state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        tmo_cnt <= '0;
    else if (state_next != cur_state) tmo_cnt <= '0;
    else if (mem_wait)                tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign mem.mem_req      = (cur_state == FETCH) || (cur_state == MEM);
  assign mem.mem_sel_data = (cur_state == MEM);
  assign mem.mem_we       = (cur_state == MEM) && dec_store;
  assign alu_en           = (cur_state == EXEC);
  assign rf_we            = (cur_state == WB);
  assign rf_wsel          = (cur_state == WB) && dec_load;
  assign rf_waddr         = ir[RD_MSB:RD_LSB];
  assign state            = cur_state;
  assign halted           = (cur_state == HALT);
  assign err              = (cur_state == ERROR);

`ifdef CPU_SEQ_PERF_CNT_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              perf_cnt <= 16'd0;
    else if (retire && perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 16'd1;
  end

  assign instr_count = perf_cnt;
`else
  assign instr_count = 16'd0;
`endif

endmodule
